// File: rtl/sb_pkg.sv
// Shared types for the store buffer: read FSM states, FIFO entry layout and default depth.
// Used by both store_buffer and sb_fifo.
package sb_pkg;

  localparam int SB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } sb_state_t;

  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side (M-stage) and memory-side buses of the store buffer.
// The master modport drives the request; the slave modport answers it.
interface sb_cpu_if;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall
  );

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall
  );
endinterface

interface sb_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/sb_fifo.sv
// Store FIFO: entry storage, wrapping pointers, occupancy count and full/empty flags.
// With STORE_BUFFER_FWD_EN defined it also finds the youngest entry matching a load address.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  output sb_entry_t   head,
  output logic        full,
  output logic        empty
`ifdef STORE_BUFFER_FWD_EN
  ,
  input  logic [31:2] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  sb_entry_t       mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_entry;
  end

`ifdef STORE_BUFFER_FWD_EN
  genvar gi;
  logic [DEPTH-1:0] match;
  logic [PW-1:0]    idx;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = (mem_reg[gi].addr == lookup_addr);
    end
  endgenerate

  // Walk oldest to youngest so the last valid match (the youngest) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PW'(k);
      if (((PW+1)'(k) < count_reg) && match[idx]) begin
        hit      = 1'b1;
        hit_data = mem_reg[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between the CPU M-stage and memory; loads take priority over draining.
// Define STORE_BUFFER_FWD_EN to forward buffered store data to matching loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  sb_cpu_if.slave   cpu,
  sb_mem_if.master  mem,
  output logic      buf_empty
);

  sb_state_t   state_reg;
  sb_state_t   state_next;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  sb_entry_t   head;
  sb_entry_t   push_entry;
  logic        load;
  logic        miss;
  logic        unused_addr_bits;

  assign push_entry.addr  = cpu.cpu_addr[31:2];
  assign push_entry.data  = cpu.cpu_wdata;
  assign unused_addr_bits = ^cpu.cpu_addr[1:0];
  // A store alongside a load wins; the load half is ignored.
  assign load             = cpu.cpu_re & ~cpu.cpu_we;
  assign buf_empty        = empty;

`ifdef STORE_BUFFER_FWD_EN
  logic        hit;
  logic [31:0] hit_data;

  assign miss = load & ~hit;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .lookup_addr (cpu.cpu_addr[31:2]),
    .hit         (hit),
    .hit_data    (hit_data)
  );
`else
  // Without forwarding a load may only go to memory once every older store has drained.
  assign miss = load & empty;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
    end
  end

  // Outputs are gated by reset so that a held CPU request cannot reach memory mid-reset.
  always_comb begin
    state_next     = state_reg;
    rdata_next     = rdata_reg;
    push           = 1'b0;
    pop            = 1'b0;
    cpu.cpu_stall  = 1'b0;
    cpu.cpu_rdata  = '0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;

    if (reset) begin
      case (state_reg)
        IDLE: begin
          if (cpu.cpu_we) begin
            cpu.cpu_stall = full;
            push          = ~full;
          end
          if (miss) begin
            mem.mem_req   = 1'b1;
            mem.mem_addr  = {cpu.cpu_addr[31:2], 2'b00};
            cpu.cpu_stall = 1'b1;
            state_next    = mem.mem_ready ? RD_WAIT : RD_REQ;
          end else begin
`ifdef STORE_BUFFER_FWD_EN
            if (load) cpu.cpu_rdata = hit_data;
`else
            if (load) cpu.cpu_stall = 1'b1;
`endif
            if (!empty) begin
              mem.mem_req   = 1'b1;
              mem.mem_we    = 1'b1;
              mem.mem_addr  = {head.addr, 2'b00};
              mem.mem_wdata = head.data;
              pop           = mem.mem_ready;
            end
          end
        end
        RD_REQ: begin
          mem.mem_req   = 1'b1;
          mem.mem_addr  = {cpu.cpu_addr[31:2], 2'b00};
          cpu.cpu_stall = 1'b1;
          if (mem.mem_ready) state_next = RD_WAIT;
        end
        RD_WAIT: begin
          cpu.cpu_stall = 1'b1;
          if (mem.mem_rvalid) begin
            rdata_next = mem.mem_rdata;
            state_next = RD_DONE;
          end
        end
        RD_DONE: begin
          cpu.cpu_rdata = rdata_reg;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); expectations follow STORE_BUFFER_FWD_EN.
module tb_store_buffer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic buf_empty;
  int   total = 0;
  int   passed = 0;

  sb_cpu_if cpu();
  sb_mem_if mem();

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu),
    .mem       (mem),
    .buf_empty (buf_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr();
    cpu.cpu_we = 1'b0; cpu.cpu_re = 1'b0; cpu.cpu_addr = '0; cpu.cpu_wdata = '0;
    mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu.cpu_we = 1'b1; cpu.cpu_re = 1'b0; cpu.cpu_addr = a; cpu.cpu_wdata = d;
  endtask

  task automatic apply_reset();
    @(negedge clk); clr(); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset();
    clr();
    cpu.cpu_re = 1'b1; cpu.cpu_addr = 32'h2000;
    #1 reset = 1'b0;
    #1;
    total++; if (buf_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", buf_empty); else passed++;
    total++; if (mem.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem.mem_req); else passed++;
    total++; if (cpu.cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu.cpu_stall); else passed++;
    total++; if (cpu.cpu_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", cpu.cpu_rdata); else passed++;
    @(negedge clk); clr(); reset = 1'b1;
  endtask

  task automatic test_store_fill();
    logic [31:0] ea;
    logic [31:0] ed;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      store(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      #1;
      total++; if (cpu.cpu_stall !== 1'b0) $display("FAIL fill_stall%0d: got %b want 0", k, cpu.cpu_stall); else passed++;
      if (k == 0) begin
        total++; if (mem.mem_req !== 1'b0) $display("FAIL fill_first_req: got %b want 0", mem.mem_req); else passed++;
      end else begin
        total++;
        if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hA0})
          $display("FAIL fill_head%0d: got req=%b we=%b a=%h d=%h want 1 1 00000100 000000a0",
                   k, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata);
        else passed++;
      end
      @(negedge clk);
    end
    store(32'h110, 32'hA4);
    #1;
    total++; if (cpu.cpu_stall !== 1'b1) $display("FAIL full_stall_a: got %b want 1", cpu.cpu_stall); else passed++;
    total++; if (buf_empty !== 1'b0) $display("FAIL full_not_empty: got %b want 0", buf_empty); else passed++;
    @(negedge clk); #1;
    total++; if (cpu.cpu_stall !== 1'b1) $display("FAIL full_stall_b: got %b want 1", cpu.cpu_stall); else passed++;
    @(negedge clk); mem.mem_ready = 1'b1; #1;
    total++; if (cpu.cpu_stall !== 1'b1) $display("FAIL full_stall_pop: got %b want 1", cpu.cpu_stall); else passed++;
    total++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hA0})
      $display("FAIL full_pop_head: got a=%h d=%h want 00000100 000000a0", mem.mem_addr, mem.mem_wdata);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b0; #1;
    total++; if (cpu.cpu_stall !== 1'b0) $display("FAIL full_accept: got %b want 0", cpu.cpu_stall); else passed++;
    total++; if (mem.mem_addr !== 32'h104) $display("FAIL full_new_head: got %h want 00000104", mem.mem_addr); else passed++;
    @(negedge clk); cpu.cpu_we = 1'b0; mem.mem_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      ea = 32'h104 + 32'(4 * j);
      ed = 32'hA1 + 32'(j);
      #1;
      total++;
      if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata} !== {1'b1, 1'b1, ea, ed})
        $display("FAIL drain%0d: got req=%b we=%b a=%h d=%h want 1 1 %h %h",
                 j, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, ea, ed);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++; if ({buf_empty, mem.mem_req} !== 2'b10) $display("FAIL drain_done: got empty=%b req=%b want 1 0", buf_empty, mem.mem_req); else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    store(32'h200, 32'h11); #1;
    total++; if (cpu.cpu_stall !== 1'b0) $display("FAIL b2b_stall_a: got %b want 0", cpu.cpu_stall); else passed++;
    @(negedge clk); store(32'h204, 32'h22); mem.mem_ready = 1'b1; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_addr} !== {1'b0, 32'h200})
      $display("FAIL b2b_push_pop: got stall=%b a=%h want 0 00000200", cpu.cpu_stall, mem.mem_addr);
    else passed++;
    @(negedge clk); clr(); #1;
    total++;
    if ({buf_empty, mem.mem_req, mem.mem_addr, mem.mem_wdata} !== {1'b0, 1'b1, 32'h204, 32'h22})
      $display("FAIL b2b_head: got empty=%b req=%b a=%h d=%h want 0 1 00000204 00000022",
               buf_empty, mem.mem_req, mem.mem_addr, mem.mem_wdata);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b1;
    @(negedge clk); mem.mem_ready = 1'b0; #1;
    total++; if (buf_empty !== 1'b1) $display("FAIL b2b_empty: got %b want 1", buf_empty); else passed++;
  endtask

`ifdef STORE_BUFFER_FWD_EN
  task automatic test_forward();
    apply_reset();
    store(32'h1000, 32'hAAAA);
    @(negedge clk); store(32'h1000, 32'hBBBB);
    @(negedge clk); clr(); cpu.cpu_re = 1'b1; cpu.cpu_addr = 32'h1000; #1;
    total++;
    if ({cpu.cpu_stall, cpu.cpu_rdata} !== {1'b0, 32'hBBBB})
      $display("FAIL fwd_hit: got stall=%b rdata=%h want 0 0000bbbb", cpu.cpu_stall, cpu.cpu_rdata);
    else passed++;
    total++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata} !== {1'b1, 1'b1, 32'h1000, 32'hAAAA})
      $display("FAIL fwd_mem_write: got req=%b we=%b a=%h d=%h want 1 1 00001000 0000aaaa",
               mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata);
    else passed++;
    @(negedge clk); cpu.cpu_addr = 32'h1002; #1;
    total++; if (cpu.cpu_rdata !== 32'hBBBB) $display("FAIL fwd_lowbits: got %h want 0000bbbb", cpu.cpu_rdata); else passed++;
    @(negedge clk); cpu.cpu_addr = 32'h1004; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h1004})
      $display("FAIL fwd_miss_read: got stall=%b req=%b we=%b a=%h want 1 1 0 00001004",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr);
    else passed++;
  endtask
`else
  task automatic test_drain_order();
    apply_reset();
    store(32'h1000, 32'hAAAA);
    @(negedge clk); store(32'h1008, 32'hBBBB);
    @(negedge clk); clr(); cpu.cpu_re = 1'b1; cpu.cpu_addr = 32'h1000; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata} !== {1'b1, 1'b1, 1'b1, 32'h1000, 32'hAAAA})
      $display("FAIL order_w0_wait: got stall=%b req=%b we=%b a=%h d=%h want 1 1 1 00001000 0000aaaa",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b1; #1;
    total++;
    if ({mem.mem_we, mem.mem_addr} !== {1'b1, 32'h1000})
      $display("FAIL order_w0: got we=%b a=%h want 1 00001000", mem.mem_we, mem.mem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata} !== {1'b1, 1'b1, 1'b1, 32'h1008, 32'hBBBB})
      $display("FAIL order_w1: got stall=%b req=%b we=%b a=%h d=%h want 1 1 1 00001008 0000bbbb",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h1000})
      $display("FAIL order_read: got stall=%b req=%b we=%b a=%h want 1 1 0 00001000",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h5555; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req} !== 2'b10)
      $display("FAIL order_rwait: got stall=%b req=%b want 1 0", cpu.cpu_stall, mem.mem_req);
    else passed++;
    @(negedge clk); mem.mem_rvalid = 1'b0; #1;
    total++;
    if ({cpu.cpu_stall, cpu.cpu_rdata} !== {1'b0, 32'h5555})
      $display("FAIL order_rdone: got stall=%b rdata=%h want 0 00005555", cpu.cpu_stall, cpu.cpu_rdata);
    else passed++;
    @(negedge clk); clr();
  endtask
`endif

  task automatic test_load_miss();
    apply_reset();
    cpu.cpu_re = 1'b1; cpu.cpu_addr = 32'h2000; mem.mem_ready = 1'b1; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h2000})
      $display("FAIL miss_issue: got stall=%b req=%b we=%b a=%h want 1 1 0 00002000",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b0; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req} !== 2'b10)
      $display("FAIL miss_wait1: got stall=%b req=%b want 1 0", cpu.cpu_stall, mem.mem_req);
    else passed++;
    @(negedge clk); mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h1234; #1;
    total++; if (cpu.cpu_stall !== 1'b1) $display("FAIL miss_wait2: got %b want 1", cpu.cpu_stall); else passed++;
    @(negedge clk); mem.mem_rvalid = 1'b0; #1;
    total++;
    if ({cpu.cpu_stall, cpu.cpu_rdata} !== {1'b0, 32'h1234})
      $display("FAIL miss_done: got stall=%b rdata=%h want 0 00001234", cpu.cpu_stall, cpu.cpu_rdata);
    else passed++;
    @(negedge clk); clr(); #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, cpu.cpu_rdata} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL miss_idle: got stall=%b req=%b rdata=%h want 0 0 0", cpu.cpu_stall, mem.mem_req, cpu.cpu_rdata);
    else passed++;
    @(negedge clk); cpu.cpu_re = 1'b1; cpu.cpu_addr = 32'h3004; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h3004})
      $display("FAIL rdreq_issue: got stall=%b req=%b we=%b a=%h want 1 1 0 00003004",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h3004})
      $display("FAIL rdreq_hold: got stall=%b req=%b we=%b a=%h want 1 1 0 00003004",
               cpu.cpu_stall, mem.mem_req, mem.mem_we, mem.mem_addr);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b1;
    @(negedge clk); mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hCAFE; #1;
    total++;
    if ({cpu.cpu_stall, mem.mem_req} !== 2'b10)
      $display("FAIL rdreq_wait: got stall=%b req=%b want 1 0", cpu.cpu_stall, mem.mem_req);
    else passed++;
    @(negedge clk); mem.mem_rvalid = 1'b0; #1;
    total++;
    if ({cpu.cpu_stall, cpu.cpu_rdata} !== {1'b0, 32'hCAFE})
      $display("FAIL rdreq_done: got stall=%b rdata=%h want 0 0000cafe", cpu.cpu_stall, cpu.cpu_rdata);
    else passed++;
    @(negedge clk); clr();
  endtask

  task automatic test_reset_midread();
    apply_reset();
    store(32'h40, 32'h1);
    @(negedge clk); store(32'h44, 32'h2);
    @(negedge clk); store(32'h48, 32'h3);
    @(negedge clk);
`ifdef STORE_BUFFER_FWD_EN
    cpu.cpu_we = 1'b0; cpu.cpu_re = 1'b1; cpu.cpu_addr = 32'h4000; mem.mem_ready = 1'b1; #1;
    total++;
    if ({mem.mem_req, mem.mem_we} !== 2'b10)
      $display("FAIL rst_read_issue: got req=%b we=%b want 1 0", mem.mem_req, mem.mem_we);
    else passed++;
    @(negedge clk); mem.mem_ready = 1'b0; #1;
    total++;
    if ({cpu.cpu_stall, buf_empty} !== 2'b10)
      $display("FAIL rst_in_rdwait: got stall=%b empty=%b want 1 0", cpu.cpu_stall, buf_empty);
    else passed++;
`else
    cpu.cpu_we = 1'b0; #1;
    total++;
    if ({mem.mem_req, buf_empty} !== 2'b10)
      $display("FAIL rst_buffered: got req=%b empty=%b want 1 0", mem.mem_req, buf_empty);
    else passed++;
`endif
    #2 reset = 1'b0;
    #1;
    total++;
    if ({buf_empty, mem.mem_req, cpu.cpu_stall} !== 3'b100)
      $display("FAIL rst_async: got empty=%b req=%b stall=%b want 1 0 0", buf_empty, mem.mem_req, cpu.cpu_stall);
    else passed++;
    @(negedge clk); clr();
    @(negedge clk); reset = 1'b1; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEAD; #1;
    total++;
    if ({mem.mem_req, cpu.cpu_stall, cpu.cpu_rdata, buf_empty} !== {1'b0, 1'b0, 32'h0, 1'b1})
      $display("FAIL rst_stray_a: got req=%b stall=%b rdata=%h empty=%b want 0 0 0 1",
               mem.mem_req, cpu.cpu_stall, cpu.cpu_rdata, buf_empty);
    else passed++;
    @(negedge clk); mem.mem_rvalid = 1'b0; #1;
    total++;
    if ({mem.mem_req, cpu.cpu_stall, cpu.cpu_rdata, buf_empty} !== {1'b0, 1'b0, 32'h0, 1'b1})
      $display("FAIL rst_stray_b: got req=%b stall=%b rdata=%h empty=%b want 0 0 0 1",
               mem.mem_req, cpu.cpu_stall, cpu.cpu_rdata, buf_empty);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_fill();
    test_back_to_back();
`ifdef STORE_BUFFER_FWD_EN
    test_forward();
`else
    test_drain_order();
`endif
    test_load_miss();
    test_reset_midread();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 cpu_we  input  1  M-stage store (sw) request.
REQ-005 cpu_re  input  1  M-stage load (lw) request.
REQ-006 cpu_addr  input  32  byte address; bits [1:0] ignored (word access).
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_rdata  output  32  load data; valid when cpu_re=1 and cpu_stall=0.
REQ-009 cpu_stall  output  1  request not completed this cycle; CPU holds the M-stage and keeps the request stable.
REQ-010 mem_req, mem_we  output  1 each  memory request valid; 1 = write.
REQ-011 mem_addr, mem_wdata  output  32 each  word address with [1:0]=0; write data.
REQ-012 mem_ready  input  1  memory accepts the request this cycle.
REQ-013 mem_rvalid, mem_rdata  input  1, 32  read data return, one or more cycles after acceptance.
REQ-014 buf_empty  output  1  no buffered stores.

Function
REQ-015 Stores enter a FIFO of DEPTH entries {word address, data}; entry count is held in a $clog2(DEPTH)+1-bit counter; pointers wrap modulo DEPTH.
REQ-016 Store, not full: accepted in the same cycle, cpu_stall=0, entry written at the rising edge.
REQ-017 Store, full: cpu_stall=1; accepted in the first cycle in which the count is below DEPTH.
REQ-018 Push and pop in the same cycle: both occur; count unchanged.
REQ-019 cpu_we=1 together with cpu_re=1: treated as a store only.
REQ-020 FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
REQ-021 IDLE, load miss: drive a read request (mem_req=1, mem_we=0) in the same cycle, taking priority over draining.
  - mem_ready=1: go to RD_WAIT.
  - mem_ready=0: go to RD_REQ.
REQ-022 RD_REQ: hold the read request; go to RD_WAIT on mem_ready.
REQ-023 RD_WAIT: on mem_rvalid, register mem_rdata and go to RD_DONE.
REQ-024 RD_DONE: cpu_stall=0, cpu_rdata = registered data; go to IDLE.
REQ-025 cpu_stall=1 for a load miss in every cycle from IDLE through RD_WAIT.
REQ-026 Drain: in IDLE, with no load present and the buffer non-empty, issue mem_req=1, mem_we=1 for the head entry; pop the head on mem_ready.
REQ-027 No drain is issued in RD_REQ, RD_WAIT or RD_DONE.
REQ-028 The buffer drains strictly in order; an unaccepted request keeps its address and data stable.
REQ-029 Outputs are 0 when idle: mem_req=0, cpu_stall=0 unless REQ-017/025 applies, cpu_rdata=0 unless a load is completing.

Reset
REQ-030 reset=0 asserts immediately, regardless of clock:
  - count and both pointers = 0; FSM = IDLE; read-data register = 0;
  - mem_req=0, cpu_stall=0, buf_empty=1.
REQ-031 Reset during operation discards all buffered stores and any outstanding read.
REQ-032 After reset, mem_rvalid is ignored until a new read is issued.

Configuration
REQ-033 Macro STORE_BUFFER_FWD_EN defined:
  - a load whose word address matches one or more entries is a hit;
  - the hit returns the youngest matching entry's data in the same cycle, with cpu_stall=0 and no memory access;
  - any other load is a miss.
REQ-034 Macro not defined:
  - a load with the buffer non-empty stalls while the buffer drains;
  - once the buffer is empty, the load is handled as a miss;
  - no address comparators are present.

Structure
REQ-035 Shared package sb_pkg holds:
  - the FSM state enum;
  - the entry struct {addr[31:2], data[31:0]};
  - the DEPTH default constant.
REQ-036 One sub-module, sb_fifo: storage, pointers, count, full/empty, and the youngest-match search (the search only under STORE_BUFFER_FWD_EN).

Verification
REQ-037 Back-to-back stores with mem_ready=0, DEPTH=4:
  - stores 1-4 give cpu_stall=0;
  - the fifth store gives cpu_stall=1 until mem_ready=1 pops one entry, then is accepted.
REQ-038 Store 0x1000<-0xAAAA then 0x1000<-0xBBBB, mem_ready=0, then lw 0x1000 (FWD_EN): cpu_rdata=0xBBBB in the same cycle, cpu_stall=0, mem_req stays a write.
REQ-039 lw 0x2000 miss, mem_ready=1, mem_rvalid two cycles later with 0x1234:
  - cpu_stall=1 for three cycles;
  - RD_DONE gives cpu_rdata=0x1234, cpu_stall=0.
REQ-040 Without FWD_EN: two buffered stores, then lw 0x1000; the load's mem_req read is issued only after both writes are accepted, in FIFO order.
REQ-041 reset=0 asserted in RD_WAIT with three stores buffered:
  - buf_empty=1 and mem_req=0 immediately;
  - a later stray mem_rvalid changes no output.
